// File: rtl/strip_fill_manager.sv
// -----------------------------------------------------------------------------
// strip_fill_manager
//
// Keeps the fill level of up to NUM_STRIPS strips. For each item it walks the
// table once, in first-fit order, and collects the first three strips the item
// fits in. Each candidate is presented as (id, fill after placement) to an
// external three-input min-width selector. The selector's registered choice is
// then validated against the candidates and written back into the table.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   clr               zero the whole table (acted on only while idle)
//   req_valid/ready   item handshake; req_width sampled on accept
//   sel_en            one-cycle strobe asking the selector to register a choice
//   cand_id1..3       candidate strip ids (slot 1 has highest priority)
//   cand_width1..3    fill each candidate would have after placement
//   opt_id/opt_width  selector's registered choice, sampled one cycle after sel_en
//   resp_valid        one-cycle completion pulse
//   resp_ok           1 = placed, 0 = rejected (no fit, bad width, bad choice)
//   resp_id/resp_fill strip written and its new fill (both 0 on reject)
// -----------------------------------------------------------------------------
module strip_fill_manager #(
    parameter int NUM_STRIPS = 16,
    parameter int CAPACITY   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_width,
    output logic       sel_en,
    output logic [3:0] cand_id1,
    output logic [3:0] cand_id2,
    output logic [3:0] cand_id3,
    output logic [6:0] cand_width1,
    output logic [6:0] cand_width2,
    output logic [6:0] cand_width3,
    input  logic [3:0] opt_id,
    input  logic [6:0] opt_width,
    output logic       resp_valid,
    output logic       resp_ok,
    output logic [3:0] resp_id,
    output logic [6:0] resp_fill
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        SEL    = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Fit arithmetic is done on 8 bits so fill+width can never wrap back
    // under the capacity.
    localparam logic [7:0] CAP8     = 8'(CAPACITY);
    localparam logic [3:0] LAST_IDX = 4'(NUM_STRIPS - 1);

    state_t     state_q, state_d;
    logic       ready_q, ready_d;
    logic [6:0] fill_q [NUM_STRIPS];
    logic [6:0] fill_d [NUM_STRIPS];
    logic [6:0] width_q, width_d;
    logic [3:0] idx_q, idx_d;
    logic [1:0] found_q, found_d;
    logic [3:0] cid_q [3];
    logic [3:0] cid_d [3];
    logic [6:0] cw_q [3];
    logic [6:0] cw_d [3];
    logic       resp_valid_q, resp_valid_d;
    logic       resp_ok_q, resp_ok_d;
    logic [3:0] resp_id_q, resp_id_d;
    logic [6:0] resp_fill_q, resp_fill_d;

    logic [6:0] cur_fill;
    logic [7:0] sum;
    logic       fits;
    logic       bad_width;
    logic       opt_match;
    logic       cand_vis;

    // Fill of the strip currently being examined.
    always_comb begin
        cur_fill = '0;
        for (int i = 0; i < NUM_STRIPS; i++) begin
            if (idx_q == 4'(i)) begin
                cur_fill = fill_q[i];
            end
        end
    end

    assign sum       = {1'b0, cur_fill} + {1'b0, width_q};
    assign fits      = (sum <= CAP8);
    assign bad_width = (width_q == 7'd0) || ({1'b0, width_q} > CAP8);

    // The selector's answer is trusted only if it names one of the candidates
    // together with that candidate's own resulting width.
    always_comb begin
        opt_match = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ((cid_q[i] == opt_id) && (cw_q[i] == opt_width)) begin
                opt_match = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        idx_d        = idx_q;
        found_d      = found_q;
        fill_d       = fill_q;
        cid_d        = cid_q;
        cw_d         = cw_q;
        resp_valid_d = 1'b0;
        resp_ok_d    = 1'b0;
        resp_id_d    = '0;
        resp_fill_d  = '0;

        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    for (int i = 0; i < NUM_STRIPS; i++) begin
                        fill_d[i] = '0;
                    end
                end else if (req_valid && ready_q) begin
                    width_d = req_width;
                    idx_d   = '0;
                    found_d = '0;
                    for (int i = 0; i < 3; i++) begin
                        cid_d[i] = '0;
                        cw_d[i]  = '0;
                    end
                    state_d = SCAN;
                end
            end

            SCAN: begin
                if (bad_width) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                end else begin
                    if (fits) begin
                        for (int i = 0; i < 3; i++) begin
                            if (found_q == 2'(i)) begin
                                cid_d[i] = idx_q;
                                cw_d[i]  = sum[6:0];
                            end
                        end
                        found_d = found_q + 2'd1;
                    end

                    if (fits && (found_q == 2'd2)) begin
                        state_d = SEL;
                    end else if (idx_q == LAST_IDX) begin
                        if (found_d == 2'd0) begin
                            state_d      = DONE;
                            resp_valid_d = 1'b1;
                        end else begin
                            // Fewer than three fits: unused slots mirror slot 1
                            // so any tie in the selector lands on slot 1.
                            if (found_d < 2'd2) begin
                                cid_d[1] = cid_d[0];
                                cw_d[1]  = cw_d[0];
                            end
                            cid_d[2] = cid_d[0];
                            cw_d[2]  = cw_d[0];
                            state_d  = SEL;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end

            SEL: begin
                state_d = COMMIT;
            end

            COMMIT: begin
                resp_valid_d = 1'b1;
                if (opt_match) begin
                    for (int i = 0; i < NUM_STRIPS; i++) begin
                        if (opt_id == 4'(i)) begin
                            fill_d[i] = opt_width;
                        end
                    end
                    resp_ok_d   = 1'b1;
                    resp_id_d   = opt_id;
                    resp_fill_d = opt_width;
                end
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is registered so it stays low through the reset cycle and
        // rises on the first cycle after reset is released.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            idx_q        <= '0;
            found_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            resp_id_q    <= '0;
            resp_fill_q  <= '0;
            for (int i = 0; i < NUM_STRIPS; i++) begin
                fill_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            idx_q        <= idx_d;
            found_q      <= found_d;
            resp_valid_q <= resp_valid_d;
            resp_ok_q    <= resp_ok_d;
            resp_id_q    <= resp_id_d;
            resp_fill_q  <= resp_fill_d;
            fill_q       <= fill_d;
        end
    end

    // Item width and candidate slots are pure data; they are always reloaded
    // before use and are masked at the outputs while not meaningful.
    always_ff @(posedge clk) begin
        width_q <= width_d;
        cid_q   <= cid_d;
        cw_q    <= cw_d;
    end

    assign cand_vis = (state_q == SEL) || (state_q == COMMIT) || (state_q == DONE);

    assign req_ready   = ready_q & ~clr;
    assign sel_en      = (state_q == SEL);
    assign cand_id1    = cand_vis ? cid_q[0] : 4'd0;
    assign cand_id2    = cand_vis ? cid_q[1] : 4'd0;
    assign cand_id3    = cand_vis ? cid_q[2] : 4'd0;
    assign cand_width1 = cand_vis ? cw_q[0] : 7'd0;
    assign cand_width2 = cand_vis ? cw_q[1] : 7'd0;
    assign cand_width3 = cand_vis ? cw_q[2] : 7'd0;
    assign resp_valid  = resp_valid_q;
    assign resp_ok     = resp_ok_q;
    assign resp_id     = resp_id_q;
    assign resp_fill   = resp_fill_q;

endmodule
